pokey_pot_scanner: RTL
======================

# pokey_pot_scanner

Parametrised potentiometer scanner for the POKEY I/O section. It replaces the fixed two-channel pot logic with NUM_POTS channels and adds a POTGO-triggered dump/scan sequence, a live ALLPOT status word, and a fast-scan mode. It also ends the scan early once every channel has been captured. It sits between the analog pot comparator pins and the POKEY register read mux.

## Interface
- NUM_POTS, 8, number of pot channels (1..8)
- CNT_W, 8, counter and POT register width (≥ 8; MAX_COUNT < 2^CNT_W)
- MAX_COUNT, 228, terminal count; uncaptured channels read this value
- DUMP_CYCLES, 2, o2 cycles the dump transistors stay on after POTGO (≥ 1)

Ports (clock and reset first):
- o2  in  1  system clock; all logic is on posedge
- reset  in  1  asynchronous, active-high; clears all state
- pot_in  in  NUM_POTS  comparator outputs, asynchronous; 1 = capacitor crossed threshold
- line_strobe  in  1  one-o2 pulse per scan line; this is the count tick in slow mode
- fast_mode  in  1  1 = tick every o2; sampled on potgo_wr
- potgo_wr  in  1  one-cycle POTGO write strobe
- rd_addr  in  $clog2(NUM_POTS)+1  register select: 0..NUM_POTS-1 = POTn, NUM_POTS = ALLPOT
- data_out  out  CNT_W  selected register value, combinational from rd_addr; out-of-range addresses read 0
- allpot  out  NUM_POTS  1 = channel still counting
- pot_dump  out  NUM_POTS  dump transistor enables, all bits equal
- scan_busy  out  1  high in DUMP or SCAN
- scan_done  out  1  one-cycle pulse when the scan ends

## Operation
States are IDLE, DUMP and SCAN.

- **Reset** sets state IDLE, all POTn = 0, allpot = 0, counter = 0, pot_dump = all 1, scan_busy = 0, scan_done = 0, and clears both synchroniser stages.
- **IDLE**
  - pot_dump = 1.
  - POT registers hold their last values.
  - potgo_wr → DUMP. In the same edge: POTn ← 0, allpot ← all 1, counter ← 0, dump timer ← 0, latch fast_mode.
- **DUMP**
  - pot_dump = 1 and the dump timer increments.
  - When the timer reaches DUMP_CYCLES-1 → SCAN.
- **SCAN**
  - pot_dump = 0.
  - tick = latched fast_mode ? 1 : line_strobe.
  - For each channel i with allpot[i] = 1 and synchronised pot_in[i] = 1: POTi ← current (pre-increment) counter, allpot[i] ← 0.
  - If tick and counter == MAX_COUNT: every channel still set gets POTi ← MAX_COUNT and allpot[i] ← 0. scan_done pulses and the state returns to IDLE.
  - Else if tick: counter increments.
  - If allpot reaches all 0 through captures, the scan ends early the next cycle: scan_done pulses and the state returns to IDLE.
- **potgo_wr during DUMP or SCAN** restarts the sequence exactly as from IDLE. No scan_done pulse is produced for the aborted scan.
- **Capture versus terminal tick** in the same cycle: the capture wins, so the channel gets the counter value rather than MAX_COUNT.
- **Glitches**: a pot_in that falls after capture has no effect. Only the first rising level is captured.
- **Counter** never wraps, because MAX_COUNT < 2^CNT_W.

## Timing
- pot_in passes through a 2-flop synchroniser. The captured value is the counter value 2 cycles after the pin rise, with a ±1 cycle metastability tolerance.
- POTGO to first SCAN cycle takes DUMP_CYCLES + 1 edges.
- Fast mode, no captures: scan_done fires MAX_COUNT+1 cycles after SCAN entry.
- data_out and allpot are visible in the same cycle as the update edge, with no added read latency.
- Reset mid-scan is immediate (asynchronous). No scan_done is produced.

## Structure
- Shared package pokey_pkg holds the state enum (IDLE, DUMP, SCAN), the default constant POT_MAX_COUNT = 228, and the ALLPOT address offset function.
- Sub-module pokey_pot_channel contains the 2-flop synchroniser, the POT register and the allpot bit. It takes capture, terminal-tick and clear inputs and produces its POT value and allpot bit. It is generated NUM_POTS times.
- The top level holds the FSM, counter, dump timer and read mux.

## Test plan
1. Reset, then read all addresses: POTn = 0, ALLPOT = 0, pot_dump = 0xFF, scan_busy = 0.
2. Fast mode, potgo_wr, pot_in[2] rises 50 cycles after SCAN entry: POT2 = 52 ±1 and allpot[2] clears. With no other rises, the other POTs = 228, scan_done fires at cycle 229 and pot_dump returns to 1.
3. Slow mode, line_strobe every 114 cycles, pot_in[0] rises after the 10th strobe: POT0 = 10. Verify the counter does not move between strobes.
4. All 8 pot_in held high before POTGO: all POTn = 0 in the first SCAN cycle, and scan_done fires one cycle later (early termination).
5. potgo_wr mid-scan at counter 100: POTs clear, DUMP repeats, counter restarts at 0, and no scan_done is produced for the aborted scan.
6. reset asserted mid-SCAN: outputs immediately take their reset values. A subsequent POTGO scans normally. NUM_POTS = 3 build: rd_addr 3 returns ALLPOT and rd_addr 4..7 return 0.

Source files
------------

// File: rtl/pokey_pkg.sv
// pokey_pkg: shared types and constants for the POKEY pot scanner.
// Imported by the channel and scanner modules.
package pokey_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        SCAN = 2'd2
    } pot_state_e;

    localparam int POT_MAX_COUNT = 228;

    // ALLPOT sits directly after the last POTn register
    function automatic int allpot_addr(input int num_pots);
        return num_pots;
    endfunction

endpackage

// File: rtl/pokey_pot_channel.sv
// pokey_pot_channel: one pot input with synchroniser, POT latch
// and still-counting flag.
module pokey_pot_channel
    import pokey_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = POT_MAX_COUNT
) (
    input  logic             o2,
    input  logic             reset,
    input  logic             i_pin,
    input  logic             i_scan,
    input  logic             i_clear,
    input  logic             i_term,
    input  logic [CNT_W-1:0] i_count,
    output logic [CNT_W-1:0] o_pot,
    output logic             o_active
);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_pot;
    logic             r_active;
    logic             w_capture;

    assign w_capture = i_scan & r_active & r_sync2;
    assign o_pot     = r_pot;
    assign o_active  = r_active;

    // bring the asynchronous comparator output into the o2 domain
    always_ff @(posedge o2 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // first threshold crossing wins over the terminal tick
    always_ff @(posedge o2 or posedge reset) begin
        if (reset) begin
            r_pot    <= '0;
            r_active <= 1'b0;
        end else if (i_clear) begin
            r_pot    <= '0;
            r_active <= 1'b1;
        end else if (w_capture) begin
            r_pot    <= i_count;
            r_active <= 1'b0;
        end else if (i_term && r_active) begin
            r_pot    <= CNT_W'(MAX_COUNT);
            r_active <= 1'b0;
        end
    end

endmodule

// File: rtl/pokey_pot_scanner.sv
// pokey_pot_scanner: POTGO-driven dump/scan sequencer, shared
// counter and register read mux for NUM_POTS pot channels.
module pokey_pot_scanner
    import pokey_pkg::*;
#(
    parameter  int NUM_POTS    = 8,
    parameter  int CNT_W       = 8,
    parameter  int MAX_COUNT   = POT_MAX_COUNT,
    parameter  int DUMP_CYCLES = 2,
    localparam int ADDR_W      = $clog2(NUM_POTS) + 1
) (
    input  logic                o2,
    input  logic                reset,
    input  logic [NUM_POTS-1:0] pot_in,
    input  logic                line_strobe,
    input  logic                fast_mode,
    input  logic                potgo_wr,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CNT_W-1:0]    data_out,
    output logic [NUM_POTS-1:0] allpot,
    output logic [NUM_POTS-1:0] pot_dump,
    output logic                scan_busy,
    output logic                scan_done
);

    localparam int TMR_W = $clog2(DUMP_CYCLES) + 1;
    localparam logic [TMR_W-1:0] DUMP_LAST = TMR_W'(DUMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_COUNT);

    pot_state_e         r_state;
    pot_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [TMR_W-1:0]   r_timer;
    logic               r_fast;
    logic               r_done;
    logic               w_done;
    logic               w_scan;
    logic               w_tick;
    logic               w_term;
    logic               w_all_clear;
    logic [NUM_POTS-1:0] w_allpot;
    logic [CNT_W-1:0]   w_pot [NUM_POTS];
    logic [CNT_W-1:0]   w_data;

    assign w_scan      = (r_state == SCAN);
    assign w_tick      = r_fast | line_strobe;
    assign w_term      = w_scan & w_tick & (r_count == CNT_MAX);
    assign w_all_clear = (w_allpot == '0);

    for (genvar g = 0; g < NUM_POTS; g++) begin : g_chan
        pokey_pot_channel #(
            .CNT_W     (CNT_W),
            .MAX_COUNT (MAX_COUNT)
        ) u_chan (
            .o2       (o2),
            .reset    (reset),
            .i_pin    (pot_in[g]),
            .i_scan   (w_scan),
            .i_clear  (potgo_wr),
            .i_term   (w_term),
            .i_count  (r_count),
            .o_pot    (w_pot[g]),
            .o_active (w_allpot[g])
        );
    end

    // sequencer state register
    always_ff @(posedge o2 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // POTGO always restarts; scan ends on terminal tick or when all captured
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        if (potgo_wr) begin
            w_state_nxt = DUMP;
        end else begin
            unique case (r_state)
                IDLE: w_state_nxt = IDLE;
                DUMP: begin
                    if (r_timer == DUMP_LAST) begin
                        w_state_nxt = SCAN;
                    end
                end
                SCAN: begin
                    if (w_term || w_all_clear) begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // shared scan counter, dump timer and latched tick mode
    always_ff @(posedge o2 or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_timer <= '0;
            r_fast  <= 1'b0;
        end else if (potgo_wr) begin
            r_count <= '0;
            r_timer <= '0;
            r_fast  <= fast_mode;
        end else begin
            if (r_state == DUMP) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_scan && w_tick && r_count != CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // end-of-scan pulse, suppressed when POTGO aborts
    always_ff @(posedge o2 or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done;
        end
    end

    // register read mux; unmapped addresses read zero
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_POTS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                w_data = w_pot[i];
            end
        end
        if (rd_addr == ADDR_W'(allpot_addr(NUM_POTS))) begin
            w_data[NUM_POTS-1:0] = w_allpot;
        end
    end

    assign data_out  = w_data;
    assign allpot    = w_allpot;
    assign pot_dump  = {NUM_POTS{~w_scan}};
    assign scan_busy = (r_state != IDLE);
    assign scan_done = r_done;

endmodule
